// File: rtl/sort_pkg.sv
// Shared constants, FSM state type and the ordering predicate used by the
// BRAM bubble sorter and its read-back checker.
package sort_pkg;

   localparam int DEPTH = 32'd1024;
   localparam int AW    = 32'd10;
   localparam int DW    = 32'd32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // dir=1 expects ascending order, dir=0 descending; equal words never violate
   function automatic logic is_violation(input logic          dir,
                                         input logic [DW-1:0] prev,
                                         input logic [DW-1:0] cur);
      logic viol;
      if (dir) begin
         viol = ($signed(cur) < $signed(prev));
      end else begin
         viol = ($signed(prev) < $signed(cur));
      end
      return viol;
   endfunction

endpackage

// File: rtl/sort_checker_if.sv
// Control, status and BRAM read-port bundle of the sort checker.
interface sort_checker_if
   import sort_pkg::*;
#(
   parameter int AW = sort_pkg::AW,
   parameter int DW = sort_pkg::DW
);
   logic          start;
   logic          up;
   logic [AW-1:0] mem_addr;
   logic          mem_en;
   logic [DW-1:0] mem_rdata;
   logic          busy;
   logic          done;
   logic          pass;
   logic [AW:0]   err_cnt;
   logic [AW-1:0] first_err;
   logic [31:0]   cycles;

   modport master (
      input  start, up, mem_rdata,
      output mem_addr, mem_en, busy, done, pass, err_cnt, first_err, cycles
   );

   modport slave (
      output start, up, mem_rdata,
      input  mem_addr, mem_en, busy, done, pass, err_cnt, first_err, cycles
   );

endinterface

// File: rtl/sort_checker.sv
// Streams a sorted BRAM array back out in address order and verifies that every
// adjacent pair respects the requested direction.
module sort_checker
   import sort_pkg::*;
#(
   parameter int DEPTH = sort_pkg::DEPTH,
   parameter int AW    = sort_pkg::AW,
   parameter int DW    = sort_pkg::DW
) (
   input  logic            clk,
   input  logic            rstn,
   sort_checker_if.master  bus
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 32'd1);
   localparam logic [AW-1:0] ZERO_A    = {AW{1'b0}};
   localparam logic [AW-1:0] ONE_A     = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW:0]   ZERO_E    = {(AW+1){1'b0}};
   localparam logic [AW:0]   ONE_E     = {{AW{1'b0}}, 1'b1};

   state_t        state_r, state_nxt_s;
   logic          dir_r, dir_nxt_s;
   logic [AW-1:0] addr_r, addr_nxt_s;
   logic          en_r, en_nxt_s;
   logic          busy_r, busy_nxt_s;
   logic          done_r, done_nxt_s;
   logic          pass_r, pass_nxt_s;
   logic [AW:0]   err_cnt_r, err_cnt_nxt_s;
   logic [AW-1:0] first_err_r, first_err_nxt_s;
   logic [31:0]   cycles_r, cycles_nxt_s;
   logic          rd_vld_r, rd_vld_nxt_s;
   logic [AW-1:0] rd_idx_r, rd_idx_nxt_s;
   logic [DW-1:0] prev_r, prev_nxt_s;

   // State and datapath registers, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r     <= ST_IDLE;
         dir_r       <= 1'b0;
         addr_r      <= ZERO_A;
         en_r        <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         pass_r      <= 1'b0;
         err_cnt_r   <= ZERO_E;
         first_err_r <= ZERO_A;
         cycles_r    <= 32'd0;
         rd_vld_r    <= 1'b0;
         rd_idx_r    <= ZERO_A;
         prev_r      <= {DW{1'b0}};
      end else begin
         state_r     <= state_nxt_s;
         dir_r       <= dir_nxt_s;
         addr_r      <= addr_nxt_s;
         en_r        <= en_nxt_s;
         busy_r      <= busy_nxt_s;
         done_r      <= done_nxt_s;
         pass_r      <= pass_nxt_s;
         err_cnt_r   <= err_cnt_nxt_s;
         first_err_r <= first_err_nxt_s;
         cycles_r    <= cycles_nxt_s;
         rd_vld_r    <= rd_vld_nxt_s;
         rd_idx_r    <= rd_idx_nxt_s;
         prev_r      <= prev_nxt_s;
      end
   end

   // Next-state logic: address issue, capture/compare and result latching
   always_comb begin
      state_nxt_s     = state_r;
      dir_nxt_s       = dir_r;
      addr_nxt_s      = addr_r;
      en_nxt_s        = en_r;
      busy_nxt_s      = busy_r;
      done_nxt_s      = done_r;
      pass_nxt_s      = pass_r;
      err_cnt_nxt_s   = err_cnt_r;
      first_err_nxt_s = first_err_r;
      cycles_nxt_s    = cycles_r;
      rd_vld_nxt_s    = 1'b0;
      rd_idx_nxt_s    = addr_r;
      prev_nxt_s      = prev_r;

      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (bus.start) begin
               state_nxt_s     = ST_RUN;
               dir_nxt_s       = bus.up;
               addr_nxt_s      = ZERO_A;
               en_nxt_s        = 1'b1;
               busy_nxt_s      = 1'b1;
               done_nxt_s      = 1'b0;
               pass_nxt_s      = 1'b0;
               err_cnt_nxt_s   = ZERO_E;
               first_err_nxt_s = ZERO_A;
               cycles_nxt_s    = 32'd0;
            end else begin
               state_nxt_s = state_r;
            end
         end
         ST_RUN: begin
            cycles_nxt_s = cycles_r + 32'd1;
            rd_vld_nxt_s = 1'b1;
            if (addr_r != LAST_ADDR) begin
               addr_nxt_s = addr_r + ONE_A;
            end else begin
               addr_nxt_s = addr_r;
            end
            // rd_idx_r names the word arriving on mem_rdata this cycle
            if (rd_vld_r) begin
               prev_nxt_s = bus.mem_rdata;
               if ((rd_idx_r != ZERO_A) && is_violation(dir_r, prev_r, bus.mem_rdata)) begin
                  err_cnt_nxt_s = err_cnt_r + ONE_E;
                  if (err_cnt_r == ZERO_E) begin
                     first_err_nxt_s = rd_idx_r - ONE_A;
                  end else begin
                     first_err_nxt_s = first_err_r;
                  end
               end else begin
                  err_cnt_nxt_s = err_cnt_r;
               end
               if (rd_idx_r == LAST_ADDR) begin
                  state_nxt_s  = ST_DONE;
                  en_nxt_s     = 1'b0;
                  busy_nxt_s   = 1'b0;
                  done_nxt_s   = 1'b1;
                  pass_nxt_s   = (err_cnt_nxt_s == ZERO_E);
                  rd_vld_nxt_s = 1'b0;
               end else begin
                  state_nxt_s = ST_RUN;
               end
            end else begin
               prev_nxt_s = prev_r;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            en_nxt_s    = 1'b0;
            busy_nxt_s  = 1'b0;
         end
      endcase
   end

   assign bus.mem_addr  = addr_r;
   assign bus.mem_en    = en_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.pass      = pass_r;
   assign bus.err_cnt   = err_cnt_r;
   assign bus.first_err = first_err_r;
   assign bus.cycles    = cycles_r;

endmodule

// File: tb/tb_sort_checker.sv
// Scoreboard bench for sort_checker with DEPTH=8 and a 1-cycle BRAM model.
module tb_sort_checker;
   import sort_pkg::*;

   localparam int TD  = 8;
   localparam int TAW = 3;
   localparam int TDW = 32;

   typedef logic [TDW-1:0] arr_t [TD];
   typedef struct {
      string       name;
      logic        pass;
      logic [31:0] err_cnt;
      logic [31:0] first_err;
      logic [31:0] cycles;
   } exp_t;

   logic clk;
   logic rstn;
   arr_t mem;
   exp_t sb_q [$];
   int   n_cmp;
   int   n_bad;

   sort_checker_if #(.AW(TAW), .DW(TDW)) bus ();

   sort_checker #(.DEPTH(TD), .AW(TAW), .DW(TDW)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.mem_en) bus.mem_rdata <= mem[bus.mem_addr];
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic push_exp(input string name, input logic p, input int e, input int f);
      exp_t x;
      x.name = name; x.pass = p; x.err_cnt = e; x.first_err = f; x.cycles = TD + 1;
      sb_q.push_back(x);
   endtask

   function automatic exp_t model(input arr_t a, input logic dir, input string name);
      exp_t x;
      logic v;
      x.name = name; x.err_cnt = 0; x.first_err = 0; x.cycles = TD + 1;
      for (int i = 1; i < TD; i++) begin
         v = dir ? ($signed(a[i-1]) > $signed(a[i])) : ($signed(a[i-1]) < $signed(a[i]));
         if (v) begin
            if (x.err_cnt == 0) x.first_err = i - 1;
            x.err_cnt++;
         end
      end
      x.pass = (x.err_cnt == 0);
      return x;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_busy"}, bus.busy, 0);
      check_eq({tag, "_done"}, bus.done, 0);
      check_eq({tag, "_pass"}, bus.pass, 0);
      check_eq({tag, "_en"}, bus.mem_en, 0);
      check_eq({tag, "_addr"}, bus.mem_addr, 0);
      check_eq({tag, "_err_cnt"}, bus.err_cnt, 0);
      check_eq({tag, "_first_err"}, bus.first_err, 0);
      check_eq({tag, "_cycles"}, bus.cycles, 0);
   endtask

   task automatic run_scan(input logic dir, input int start_at, input int rst_at);
      int   n;
      bit   seen;
      exp_t x;
      @(negedge clk);
      bus.up    = dir;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.up    = ~dir;
      n = 0;
      check_eq("busy_after_start", bus.busy, 1);
      check_eq("done_after_start", bus.done, 0);
      check_eq("en_after_start", bus.mem_en, 1);
      check_eq("addr_after_start", bus.mem_addr, 0);
      seen = 1'b0;
      while (!seen && n < 40) begin
         bus.start = (n == start_at);
         if (n == rst_at) begin
            rstn      = 1'b0;
            bus.start = 1'b1;
            @(negedge clk);
            rstn      = 1'b1;
            bus.start = 1'b0;
            check_reset_outputs("abort");
            return;
         end
         @(negedge clk);
         n++;
         if (bus.done) begin
            seen = 1'b1;
         end else begin
            check_eq("addr_seq", bus.mem_addr, (n < TD) ? n : TD - 1);
            check_eq("busy_run", bus.busy, 1);
         end
      end
      bus.start = 1'b0;
      check_eq("done_seen", seen, 1);
      check_eq("latency", n, TD + 1);
      check_eq("busy_done", bus.busy, 0);
      check_eq("en_done", bus.mem_en, 0);
      if (sb_q.size() == 0) begin
         check_eq("sb_empty", sb_q.size(), 1);
      end else begin
         x = sb_q.pop_front();
         check_eq({x.name, "_pass"}, bus.pass, x.pass);
         check_eq({x.name, "_err_cnt"}, bus.err_cnt, x.err_cnt);
         check_eq({x.name, "_first_err"}, bus.first_err, x.first_err);
         check_eq({x.name, "_cycles"}, bus.cycles, x.cycles);
         @(negedge clk);
         check_eq({x.name, "_done_hold"}, bus.done, 1);
         check_eq({x.name, "_err_hold"}, bus.err_cnt, x.err_cnt);
      end
   endtask

   initial begin
      arr_t a;
      n_cmp = 0;
      n_bad = 0;
      rstn = 1'b0;
      bus.start = 1'b0;
      bus.up = 1'b0;
      bus.mem_rdata = '0;
      mem = '{default: 32'd0};
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rstn = 1'b1;

      mem = '{-32'sd5, -32'sd1, 32'sd0, 32'sd0, 32'sd3, 32'sd7, 32'sd9, 32'sd12};
      push_exp("asc_up", 1'b1, 0, 0);
      run_scan(1'b1, -1, -1);
      push_exp("asc_down", 1'b0, 6, 0);
      run_scan(1'b0, -1, -1);

      mem = '{32'd1, 32'd2, 32'd3, 32'd9, 32'd4, 32'd5, 32'd2, 32'd8};
      push_exp("two_viol", 1'b0, 2, 3);
      run_scan(1'b1, -1, -1);

      mem = '{32'hFFFF_FFFF, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
      push_exp("signed", 1'b1, 0, 0);
      run_scan(1'b1, -1, -1);

      mem = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
      push_exp("all_viol", 1'b0, 7, 0);
      run_scan(1'b0, -1, -1);

      mem = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd7, 32'd6};
      push_exp("last_pair", 1'b0, 1, 6);
      run_scan(1'b1, -1, -1);

      mem = '{32'sd12, 32'sd9, 32'sd7, 32'sd3, 32'sd0, 32'sd0, -32'sd1, -32'sd5};
      push_exp("desc_down", 1'b1, 0, 0);
      run_scan(1'b0, -1, -1);

      run_scan(1'b1, -1, 4);
      mem = '{-32'sd5, -32'sd1, 32'sd0, 32'sd0, 32'sd3, 32'sd7, 32'sd9, 32'sd12};
      push_exp("after_abort", 1'b1, 0, 0);
      run_scan(1'b1, -1, -1);

      push_exp("start_in_run", 1'b0, 6, 0);
      run_scan(1'b0, 3, -1);
      push_exp("restart_done", 1'b1, 0, 0);
      run_scan(1'b1, -1, -1);

      for (int t = 0; t < 4; t++) begin
         for (int i = 0; i < TD; i++) a[i] = $urandom_range(0, 6) - 3;
         mem = a;
         sb_q.push_back(model(a, t[0], $sformatf("rand%0d", t)));
         run_scan(t[0], -1, -1);
      end

      check_eq("sb_drained", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
